// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- bus bundle for dmem_arbiter.
//
// Groups the three handshake ports of the arbiter:
//   core  : c_mem_read, c_mem_write, c_address, c_wdata -> c_rdata, c_stall
//   debug : d_req, d_we, d_addr, d_wdata                -> d_rdata, d_ack
//   memory: m_req, m_we, m_addr, m_wdata                <- m_rdata, m_ack
//   status: err_timeout
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding core/debug/memory environment.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_mem_read;
    logic              c_mem_write;
    logic [ADDR_W-1:0] c_address;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              err_timeout;

    modport slave (
        input  c_mem_read, c_mem_write, c_address, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata, m_ack,
        output c_rdata, c_stall, d_rdata, d_ack,
        output m_req, m_we, m_addr, m_wdata, err_timeout
    );

    modport master (
        output c_mem_read, c_mem_write, c_address, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata, m_ack,
        input  c_rdata, c_stall, d_rdata, d_ack,
        input  m_req, m_we, m_addr, m_wdata, err_timeout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one data-memory port between the core load/store
// unit and a debug/DMA requester, with one-bit round-robin arbitration.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (core, debug, memory and status signals)
//
// Optional feature: define DMEM_ARB_TIMEOUT_EN to add a 4-bit wait counter
// that aborts an access after 16 busy cycles without m_ack, returns 0 as
// read data and sets the sticky err_timeout flag.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BUSY_C, BUSY_D, DONE_C, DONE_D} state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;          // 0: core preferred, 1: debug preferred
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic c_any, grant_c, grant_d, timed_out, busy_end;

`ifdef DMEM_ARB_TIMEOUT_EN
    logic [3:0] wait_q, wait_d;
    logic       err_q, err_d;
    // wait_q counts busy cycles already spent without m_ack
    assign timed_out = ~bus.m_ack & (wait_q == 4'hF);
`else
    assign timed_out = 1'b0;
`endif

    assign c_any    = bus.c_mem_read | bus.c_mem_write;
    assign grant_c  = c_any & (~bus.d_req | ~rr_q);
    assign grant_d  = bus.d_req & ~grant_c;
    assign busy_end = bus.m_ack | timed_out;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef DMEM_ARB_TIMEOUT_EN
        wait_d    = wait_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d   = BUSY_C;
                    rr_d      = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.c_mem_write;   // store wins over load
                    m_addr_d  = bus.c_address;
                    m_wdata_d = bus.c_wdata;
                end else if (grant_d) begin
                    state_d   = BUSY_D;
                    rr_d      = 1'b0;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                if (grant_c | grant_d) wait_d = '0;
`endif
            end
            BUSY_C, BUSY_D: begin
                if (busy_end) begin
                    m_req_d = 1'b0;
                    if (state_q == BUSY_C) begin
                        state_d = DONE_C;
                        if (timed_out)    c_rdata_d = '0;
                        else if (!m_we_q) c_rdata_d = bus.m_rdata;
                    end else begin
                        state_d = DONE_D;
                        if (timed_out)    d_rdata_d = '0;
                        else if (!m_we_q) d_rdata_d = bus.m_rdata;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    if (timed_out) err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
`endif
                end
            end
            DONE_C, DONE_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            wait_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef DMEM_ARB_TIMEOUT_EN
            wait_q    <= wait_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_ack   = (state_q == DONE_D);
    // gated by reset so the core is released while the arbiter is held in reset
    assign bus.c_stall = reset & c_any & (state_q != DONE_C);
`ifdef DMEM_ARB_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed self-checking bench for dmem_arbiter.
// Single-requester transactions come from a vector table; arbitration,
// reset mid-access and the timeout behaviour are hand-written sequences.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          dbg;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int unsigned waits;
        int unsigned exp_stall;
        int unsigned exp_done;
        bit          exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input bit dbg, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mrdata, input int unsigned waits,
                                input int unsigned exp_stall, input int unsigned exp_done,
                                input bit exp_we, input logic [31:0] exp_rdata);
        vec_t v;
        v.dbg = dbg; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.mrdata = mrdata; v.waits = waits; v.exp_stall = exp_stall;
        v.exp_done = exp_done; v.exp_we = exp_we; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        total++;
        bad++;
        $display("FAIL %s: no completion within cycle budget", name);
    endtask

    task automatic idle_inputs();
        bus.c_mem_read = 1'b0; bus.c_mem_write = 1'b0; bus.c_address = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0; bus.m_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 of an IDLE cycle, ends at posedge+1 of an IDLE cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int unsigned cyc = 0, busy = 0, stall_cnt = 0, done_cyc = 0;
        bit done = 1'b0, seen = 1'b0;
        logic [31:0] rd = '0;
        if (v.dbg) begin
            bus.d_req = 1'b1; bus.d_we = v.wr; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            bus.c_mem_read = v.rd; bus.c_mem_write = v.wr;
            bus.c_address = v.addr; bus.c_wdata = v.wdata;
        end
        while (!done && cyc < 40) begin
            if (bus.m_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({tag, "_m_addr"}, bus.m_addr, v.addr);
                    check({tag, "_m_we"}, {31'b0, bus.m_we}, {31'b0, v.exp_we});
                    if (v.wr) check({tag, "_m_wdata"}, bus.m_wdata, v.wdata);
                end
                bus.m_ack   = (busy == v.waits);
                bus.m_rdata = (busy == v.waits) ? v.mrdata : 32'h5A5A5A5A;
                busy++;
            end else begin
                bus.m_ack = 1'b0;
            end
            #4;
            if (bus.c_stall) stall_cnt++;
            if (v.dbg ? bus.d_ack : !bus.c_stall) begin
                done = 1'b1;
                done_cyc = cyc;
                rd = v.dbg ? bus.d_rdata : bus.c_rdata;
            end
            next_cycle();
            cyc++;
        end
        if (!done) fail_bound({tag, "_done"});
        else begin
            check({tag, "_done_cycle"}, done_cyc, v.exp_done);
            check({tag, "_stall_cycles"}, stall_cnt, v.exp_stall);
            check({tag, "_rdata"}, rd, v.exp_rdata);
        end
        idle_inputs();
        #4;
        check({tag, "_d_ack_low_after"}, {31'b0, bus.d_ack}, 32'd0);
        check({tag, "_m_req_low_after"}, {31'b0, bus.m_req}, 32'd0);
        next_cycle();
    endtask

    // Core read at 0x40 and debug write at 0x80 requested together, zero-wait memory.
    task automatic both_seq(input string tag, input bit hold, input int unsigned exp_grants,
                            input logic [3:0] exp_order, input int unsigned exp_dack);
        int unsigned g = 0, dack = 0;
        bit prev = 1'b0, drop_c = 1'b0, drop_d = 1'b0;
        logic [3:0] order = '0;
        bus.c_mem_read = 1'b1; bus.c_address = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h600DCAFE;
        for (int c = 0; c < 12; c++) begin
            if (drop_c) bus.c_mem_read = 1'b0;
            if (drop_d) bus.d_req = 1'b0;
            if (bus.m_req && !prev) begin
                if (g < 4) order[g] = (bus.m_addr == 32'h80);
                check($sformatf("%s_grant%0d_we", tag, g), {31'b0, bus.m_we},
                      {31'b0, bus.m_addr == 32'h80});
                g++;
            end
            prev = bus.m_req;
            bus.m_ack = bus.m_req;
            bus.m_rdata = 32'h0000C0DE;
            #4;
            if (bus.d_ack) dack++;
            if (!hold && bus.c_mem_read && !bus.c_stall) drop_c = 1'b1;
            if (!hold && bus.d_ack) drop_d = 1'b1;
            next_cycle();
        end
        check({tag, "_grants"}, g, exp_grants);
        check({tag, "_order"}, {28'b0, order}, {28'b0, exp_order});
        check({tag, "_d_ack_cycles"}, dack, exp_dack);
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.c_mem_read = 1'b1;   // c_stall must still be low under reset
        reset = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(0, 1, 0, 32'h40,       32'h0,        32'hDEADBEEF, 2, 4, 4, 0, 32'hDEADBEEF);
        vecs[1] = mk(0, 0, 1, 32'h44,       32'h12345678, 32'hAAAA5555, 0, 2, 2, 1, 32'hDEADBEEF);
        vecs[2] = mk(0, 1, 1, 32'h48,       32'hCAFEF00D, 32'h99999999, 1, 3, 3, 1, 32'hDEADBEEF);
        vecs[3] = mk(1, 0, 0, 32'h80,       32'h0,        32'h0BADF00D, 0, 0, 2, 0, 32'h0BADF00D);
        vecs[4] = mk(1, 0, 1, 32'h84,       32'h11223344, 32'hA5A5A5A5, 3, 0, 5, 1, 32'h0BADF00D);
        vecs[5] = mk(0, 1, 0, 32'h100,      32'h0,        32'h76543210, 5, 7, 7, 0, 32'h76543210);
        vecs[6] = mk(1, 0, 0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFF, 1, 0, 3, 0, 32'hFFFFFFFF);

        do_reset();
        check("rst_m_req",   {31'b0, bus.m_req}, 32'd0);
        check("rst_m_we",    {31'b0, bus.m_we}, 32'd0);
        check("rst_m_addr",  bus.m_addr, 32'd0);
        check("rst_m_wdata", bus.m_wdata, 32'd0);
        check("rst_c_rdata", bus.c_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_d_ack",   {31'b0, bus.d_ack}, 32'd0);
        check("rst_err",     {31'b0, bus.err_timeout}, 32'd0);
        check("rst_c_stall", {31'b0, bus.c_stall}, 32'd0);
        bus.c_mem_read = 1'b0;
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests right after reset: core first, debug second.
        do_reset();
        idle_inputs();
        reset = 1'b1;
        both_seq("pair", 1'b0, 2, 4'b0010, 1);
        // Both held continuously: strict alternation.
        both_seq("rr", 1'b1, 4, 4'b1010, 2);

        // Reset in the second BUSY_C cycle abandons the access.
        bus.c_mem_read = 1'b1; bus.c_address = 32'h200;
        next_cycle();
        next_cycle();
        check("midrst_m_req_before", {31'b0, bus.m_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_m_req", {31'b0, bus.m_req}, 32'd0);
        check("midrst_c_stall", {31'b0, bus.c_stall}, 32'd0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0BAD0;
        next_cycle();
        bus.c_mem_read = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #4;
            check($sformatf("midrst_late_ack_m_req%0d", c), {31'b0, bus.m_req}, 32'd0);
            check($sformatf("midrst_late_ack_d_ack%0d", c), {31'b0, bus.d_ack}, 32'd0);
            next_cycle();
        end
        check("midrst_c_rdata", bus.c_rdata, 32'd0);
        idle_inputs();
        next_cycle();
        run_vec(mk(0, 1, 0, 32'h204, 32'h0, 32'h13579BDF, 0, 2, 2, 0, 32'h13579BDF), "postrst");

`ifdef DMEM_ARB_TIMEOUT_EN
        begin
            int unsigned cyc = 0, mreq_cnt = 0, done_cyc = 0;
            bit done = 1'b0;
            bus.c_mem_read = 1'b1; bus.c_address = 32'h300;
            while (!done && cyc < 40) begin
                #4;
                if (bus.m_req) mreq_cnt++;
                if (!bus.c_stall) begin done = 1'b1; done_cyc = cyc; end
                next_cycle();
                cyc++;
            end
            if (!done) fail_bound("tmo_done");
            else begin
                check("tmo_m_req_cycles", mreq_cnt, 32'd16);
                check("tmo_done_cycle", done_cyc, 32'd17);
                check("tmo_c_rdata", bus.c_rdata, 32'd0);
                check("tmo_err", {31'b0, bus.err_timeout}, 32'd1);
            end
            idle_inputs();
            next_cycle();
            run_vec(mk(0, 1, 0, 32'h304, 32'h0, 32'h2468ACE0, 1, 3, 3, 0, 32'h2468ACE0), "tmo_after");
            check("tmo_err_sticky", {31'b0, bus.err_timeout}, 32'd1);
        end
`else
        begin
            bus.c_mem_read = 1'b1; bus.c_address = 32'h300;
            for (int c = 0; c < 24; c++) next_cycle();
            check("notmo_m_req_held", {31'b0, bus.m_req}, 32'd1);
            check("notmo_c_stall", {31'b0, bus.c_stall}, 32'd1);
            check("notmo_err", {31'b0, bus.err_timeout}, 32'd0);
            bus.m_ack = 1'b1; bus.m_rdata = 32'h2468ACE0;
            next_cycle();
            bus.m_ack = 1'b0;
            #4;
            check("notmo_stall_released", {31'b0, bus.c_stall}, 32'd0);
            check("notmo_c_rdata", bus.c_rdata, 32'h2468ACE0);
            check("notmo_err_after", {31'b0, bus.err_timeout}, 32'd0);
            next_cycle();
            idle_inputs();
            next_cycle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of all ports.
REQ-002 Parameter: DATA_W, default 32, data width of all ports.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port c_mem_read, input, 1, core load request.
REQ-006 Port c_mem_write, input, 1, core store request.
REQ-007 Port c_address, input, ADDR_W, core access address.
REQ-008 Port c_wdata, input, DATA_W, core store data (core rs2_data).
REQ-009 Port c_rdata, output, DATA_W, core load data (core mem_out), registered.
REQ-010 Port c_stall, output, 1, freezes the core while its access is incomplete.
REQ-011 Port d_req, input, 1, debug/DMA request, held until d_ack.
REQ-012 Port d_we, input, 1, debug write enable.
REQ-013 Port d_addr, input, ADDR_W, debug address.
REQ-014 Port d_wdata, input, DATA_W, debug write data.
REQ-015 Port d_rdata, output, DATA_W, debug read data, registered.
REQ-016 Port d_ack, output, 1, one-cycle completion pulse to debug.
REQ-017 Port m_req, output, 1, memory request, registered, held until m_ack.
REQ-018 Port m_we, output, 1, memory write enable.
REQ-019 Port m_addr, output, ADDR_W, memory address.
REQ-020 Port m_wdata, output, DATA_W, memory write data.
REQ-021 Port m_rdata, input, DATA_W, memory read data, valid with m_ack.
REQ-022 Port m_ack, input, 1, memory completion, any number of wait cycles.
REQ-023 Port err_timeout, output, 1, sticky memory timeout flag.

Function
REQ-024 FSM states: IDLE, BUSY_C, BUSY_D, DONE_C, DONE_D.
REQ-025 Requests are sampled only in IDLE. A core request is c_mem_read or c_mem_write. A request seen in IDLE moves the FSM to BUSY_C or BUSY_D on the next edge.
REQ-026 When core and debug both request in IDLE, the one-bit round-robin pointer picks the winner. After each grant the pointer points to the requester that was not granted. A sole requester wins regardless of the pointer.
REQ-027 In BUSY_x: m_req=1 and m_addr, m_we and m_wdata are latched from the granted requester and stay stable until m_ack. m_we=1 whenever the core asserts c_mem_write, even if c_mem_read is also asserted.
REQ-028 On m_ack in BUSY_C: capture m_rdata into c_rdata (reads only; writes leave c_rdata unchanged), drop m_req, go to DONE_C.
REQ-029 On m_ack in BUSY_D: capture m_rdata into d_rdata (reads only), drop m_req, go to DONE_D.
REQ-030 DONE_C and DONE_D each last one cycle and then return to IDLE. d_ack=1 only in DONE_D.
REQ-031 c_stall = (c_mem_read|c_mem_write) AND state != DONE_C, combinational.
REQ-032 Zero-wait memory (m_ack in the first m_req cycle): a core access stalls 2 cycles and c_stall is low in the third.
REQ-033 A debug requester must hold d_req until d_ack. Requests withdrawn before grant are ignored. A request still held in DONE_x is re-sampled in IDLE.
REQ-034 m_ack outside BUSY_x is ignored.

Reset
REQ-035 While reset=0, asynchronously: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, c_rdata=0, d_rdata=0, d_ack=0, err_timeout=0, round-robin pointer=core, timeout counter=0, c_stall=0.
REQ-036 Reset asserted mid-access abandons the access. No ack is generated after reset is released.

Configuration
REQ-037 Macro DMEM_ARB_TIMEOUT_EN, when defined, adds a 4-bit wait counter that clears on each grant and increments each BUSY_x cycle without m_ack.
REQ-038 With DMEM_ARB_TIMEOUT_EN defined: on the 16th BUSY_x cycle without m_ack, drop m_req, load 0 into the granted requester's rdata, go to DONE_x, and set err_timeout. err_timeout clears only on reset.
REQ-039 Without DMEM_ARB_TIMEOUT_EN: wait for m_ack indefinitely, err_timeout is tied 0, and no counter is present.

Verification
REQ-040 Core lw at 0x40, m_ack after 2 wait cycles with m_rdata=0xDEADBEEF -> m_addr=0x40, c_stall high 4 cycles, c_rdata=0xDEADBEEF in DONE_C.
REQ-041 Core sw with c_wdata=0x12345678, zero-wait memory -> m_we=1, m_wdata=0x12345678, stall exactly 2 cycles.
REQ-042 First cycle after reset, core read and debug write at 0x80 -> core served first, then debug; d_ack pulse for exactly 1 cycle.
REQ-043 Both request continuously for 4 grants -> grant order core, debug, core, debug.
REQ-044 With DMEM_ARB_TIMEOUT_EN defined, core read with m_ack never asserted -> m_req drops after 16 cycles, c_rdata=0, err_timeout=1 and stays set.
REQ-045 reset=0 in the second BUSY_C cycle -> m_req and c_stall go 0 immediately, FSM is in IDLE after release, and a late m_ack is ignored.
